// File: rtl/mtsp_conv_writeback.sv
// Writeback stage behind the MTSP FP<->INT conversion ALU.
// The stage carries destination tags alongside the ALU pipeline and joins each tag
// with its ALU result. It queues the results in a credit-guarded show-ahead FIFO
// and drains them to the register-file write port.
module mtsp_conv_writeback #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DST_W   = 6,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_en,
    input  logic                     issue_phase,
    input  logic [DST_W-1:0]         issue_dst,
    output logic                     issue_stall,
    input  logic [1:0]               phase_en,
    input  logic [DATA_W-1:0]        dout,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic                     wb_phase,
    output logic [DST_W-1:0]         wb_dst,
    output logic [DATA_W-1:0]        wb_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     tag_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned SUM_W = LVL_W + 1;

    // tag delay line
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_ph;
    logic [DST_W-1:0]   tag_dst [LATENCY];
    logic [LATENCY-1:0] tag_v_nxt;
    logic [LATENCY-1:0] tag_ph_nxt;
    logic [DST_W-1:0]   tag_dst_nxt [LATENCY];

    // result FIFO storage and pointers
    logic [DATA_W-1:0]  mem_data [DEPTH];
    logic [DST_W-1:0]   mem_dst  [DEPTH];
    logic               mem_ph   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr_nxt;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [LVL_W-1:0]   level_nxt;

    // join and control signals
    logic               last_v;
    logic               last_ph;
    logic [DST_W-1:0]   last_dst;
    logic [1:0]         exp_pe;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;
    logic               err_set;
    logic [SUM_W-1:0]   inflight_nxt;
    logic               stall_nxt;
    logic               head_ph_nxt;
    logic [DST_W-1:0]   head_dst_nxt;
    logic [DATA_W-1:0]  head_data_nxt;

    // Delay-line shift: stage 0 captures only credited issues
    always_comb begin
        tag_v_nxt      = '0;
        tag_ph_nxt     = '0;
        for (int i = 0; i < LATENCY; i++) begin
            tag_dst_nxt[i] = '0;
        end
        tag_v_nxt[0]   = issue_en & ~issue_stall;
        tag_ph_nxt[0]  = issue_phase;
        tag_dst_nxt[0] = issue_dst;
        for (int i = 1; i < LATENCY; i++) begin
            tag_v_nxt[i]   = tag_v[i-1];
            tag_ph_nxt[i]  = tag_ph[i-1];
            tag_dst_nxt[i] = tag_dst[i-1];
        end
    end

    // Join, FIFO bookkeeping, credit and next head contents
    always_comb begin
        last_v   = tag_v[LATENCY-1];
        last_ph  = tag_ph[LATENCY-1];
        last_dst = tag_dst[LATENCY-1];
        exp_pe   = last_ph ? 2'b10 : 2'b01;

        // a valid tag with any enable pushes; 2'b11 and wrong phase still keep the tag's phase
        push  = last_v & (phase_en != 2'b00);
        pop   = wb_valid & wb_ready;
        full  = (fifo_level == LVL_W'(DEPTH));
        wr_en = push & (~full | pop);

        err_set = (last_v ? (phase_en != exp_pe) : (phase_en != 2'b00))
                | (issue_en & issue_stall)
                | (push & full & ~pop);

        wr_ptr_nxt = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt = pop   ? rd_ptr + PTR_W'(1) : rd_ptr;

        level_nxt = fifo_level;
        case ({wr_en, pop})
            2'b10:   level_nxt = fifo_level + LVL_W'(1);
            2'b01:   level_nxt = fifo_level - LVL_W'(1);
            default: level_nxt = fifo_level;
        endcase

        inflight_nxt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_nxt = inflight_nxt + SUM_W'(tag_v_nxt[i]);
        end
        // same-cycle pops are not credited: stall depends on registered state only
        stall_nxt = (SUM_W'(level_nxt) + inflight_nxt) >= SUM_W'(DEPTH);

        head_ph_nxt   = 1'b0;
        head_dst_nxt  = '0;
        head_data_nxt = '0;
        if (level_nxt != '0) begin
            if (wr_en && (wr_ptr == rd_ptr_nxt)) begin
                head_ph_nxt   = last_ph;
                head_dst_nxt  = last_dst;
                head_data_nxt = dout;
            end else begin
                head_ph_nxt   = mem_ph[rd_ptr_nxt];
                head_dst_nxt  = mem_dst[rd_ptr_nxt];
                head_data_nxt = mem_data[rd_ptr_nxt];
            end
        end
    end

    // FIFO storage write; contents are don't-care until referenced by a valid level
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= dout;
            mem_dst[wr_ptr]  <= last_dst;
            mem_ph[wr_ptr]   <= last_ph;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v       <= '0;
            tag_ph      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_dst[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            issue_stall <= 1'b0;
            wb_valid    <= 1'b0;
            wb_phase    <= 1'b0;
            wb_dst      <= '0;
            wb_data     <= '0;
            tag_err     <= 1'b0;
        end else begin
            tag_v       <= tag_v_nxt;
            tag_ph      <= tag_ph_nxt;
            for (int i = 0; i < LATENCY; i++) begin
                tag_dst[i] <= tag_dst_nxt[i];
            end
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            fifo_level  <= level_nxt;
            issue_stall <= stall_nxt;
            wb_valid    <= (level_nxt != '0);
            wb_phase    <= head_ph_nxt;
            wb_dst      <= head_dst_nxt;
            wb_data     <= head_data_nxt;
            tag_err     <= tag_err | err_set;
        end
    end

endmodule

// File: tb/tb_mtsp_conv_writeback.sv
// Directed bench for mtsp_conv_writeback with a two-stage ALU response model.
module tb_mtsp_conv_writeback;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DST_W   = 6;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_en;
    logic              issue_phase;
    logic [DST_W-1:0]  issue_dst;
    logic              issue_stall;
    logic [1:0]        phase_en;
    logic [DATA_W-1:0] dout;
    logic              wb_valid;
    logic              wb_ready;
    logic              wb_phase;
    logic [DST_W-1:0]  wb_dst;
    logic [DATA_W-1:0] wb_data;
    logic [2:0]        fifo_level;
    logic              tag_err;

    // ALU response model: result appears two cycles after an accepted issue
    logic              alu_v  [2];
    logic              alu_ph [2];
    logic [DATA_W-1:0] alu_d  [2];
    logic [DATA_W-1:0] issue_data;
    int                pe_mode;
    logic [1:0]        man_pe;
    logic [DATA_W-1:0] man_dout;

    int passed = 0;
    int total  = 0;

    mtsp_conv_writeback #(
        .DATA_W(DATA_W), .DST_W(DST_W), .LATENCY(LATENCY), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_en(issue_en), .issue_phase(issue_phase), .issue_dst(issue_dst),
        .issue_stall(issue_stall),
        .phase_en(phase_en), .dout(dout),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_phase(wb_phase),
        .wb_dst(wb_dst), .wb_data(wb_data),
        .fifo_level(fifo_level), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    // One clock: drive ALU outputs for this cycle, step the edge, then settle
    task automatic cycle();
        logic acc;
        case (pe_mode)
            0:       phase_en = alu_v[1] ? (alu_ph[1] ? 2'b10 : 2'b01) : 2'b00;
            1:       phase_en = alu_v[1] ? (alu_ph[1] ? 2'b01 : 2'b10) : 2'b00;
            2:       phase_en = man_pe;
            default: phase_en = alu_v[1] ? 2'b11 : 2'b00;
        endcase
        dout = (pe_mode == 2) ? man_dout : alu_d[1];
        acc  = issue_en & ~issue_stall;
        @(posedge clk);
        alu_v[1]  = alu_v[0];
        alu_ph[1] = alu_ph[0];
        alu_d[1]  = alu_d[0];
        alu_v[0]  = acc;
        alu_ph[0] = issue_phase;
        alu_d[0]  = issue_data;
        #1;
    endtask

    task automatic issue(input logic ph, input logic [DST_W-1:0] dst);
        issue_en    = 1'b1;
        issue_phase = ph;
        issue_dst   = dst;
        issue_data  = 32'hC0DE_0000 | 32'(dst);
    endtask

    task automatic idle();
        issue_en    = 1'b0;
        issue_phase = 1'b0;
        issue_dst   = '0;
        issue_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        pe_mode  = 0;
        wb_ready = 1'b0;
        rst      = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            alu_v[i]  = 1'b0;
            alu_ph[i] = 1'b0;
            alu_d[i]  = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (wb_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", wb_valid); else passed++;
        total++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
        total++; if (issue_stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", issue_stall); else passed++;
        total++; if (tag_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", tag_err); else passed++;
        total++; if ({wb_phase, wb_dst, wb_data} !== '0) $display("FAIL reset_head: got %0h want 0", {wb_phase, wb_dst, wb_data}); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        wb_ready = 1'b1;
        issue(1'b0, 6'd5);
        issue_data = 32'h0000_1234;
        cycle();
        idle();
        cycle();
        total++; if (wb_valid !== 1'b0) $display("FAIL single_early: got %0b want 0", wb_valid); else passed++;
        cycle();
        total++; if (wb_valid !== 1'b1) $display("FAIL single_valid: got %0b want 1", wb_valid); else passed++;
        total++; if (wb_dst !== 6'd5) $display("FAIL single_dst: got %0d want 5", wb_dst); else passed++;
        total++; if (wb_phase !== 1'b0) $display("FAIL single_phase: got %0b want 0", wb_phase); else passed++;
        total++; if (wb_data !== 32'h0000_1234) $display("FAIL single_data: got %h want 00001234", wb_data); else passed++;
        cycle();
        total++; if (wb_valid !== 1'b0) $display("FAIL single_drain: got %0b want 0", wb_valid); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL single_zero: got %h want 0", wb_data); else passed++;
        total++; if (tag_err !== 1'b0) $display("FAIL single_err: got %0b want 0", tag_err); else passed++;
    endtask

    task automatic test_credit();
        do_reset();
        issue(1'b0, 6'd1); cycle();
        issue(1'b0, 6'd2); cycle();
        issue(1'b0, 6'd3); cycle();
        total++; if (issue_stall !== 1'b0) $display("FAIL credit_stall3: got %0b want 0", issue_stall); else passed++;
        issue(1'b0, 6'd4); cycle();
        total++; if (issue_stall !== 1'b1) $display("FAIL credit_stall4: got %0b want 1", issue_stall); else passed++;
        idle();
        cycle();
        total++; if (wb_dst !== 6'd1) $display("FAIL credit_hold1: got %0d want 1", wb_dst); else passed++;
        cycle();
        total++; if (fifo_level !== 3'd4) $display("FAIL credit_level: got %0d want 4", fifo_level); else passed++;
        total++; if (issue_stall !== 1'b1) $display("FAIL credit_full_stall: got %0b want 1", issue_stall); else passed++;
        wb_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (wb_valid !== 1'b1 || wb_dst !== DST_W'(i))
                $display("FAIL credit_drain%0d: got v=%0b dst=%0d want v=1 dst=%0d", i, wb_valid, wb_dst, i);
            else passed++;
            total++; if (wb_data !== (32'hC0DE_0000 | 32'(i)))
                $display("FAIL credit_data%0d: got %h want %h", i, wb_data, 32'hC0DE_0000 | 32'(i));
            else passed++;
            if (i == 2) begin
                total++; if (issue_stall !== 1'b0) $display("FAIL credit_unstall: got %0b want 0", issue_stall); else passed++;
            end
            cycle();
        end
        total++; if (wb_valid !== 1'b0 || fifo_level !== 3'd0)
            $display("FAIL credit_empty: got v=%0b lvl=%0d want v=0 lvl=0", wb_valid, fifo_level);
        else passed++;
    endtask

    task automatic test_wrong_phase();
        do_reset();
        pe_mode = 1;
        issue(1'b1, 6'd7); cycle();
        idle(); cycle();
        total++; if (tag_err !== 1'b0) $display("FAIL wrongph_early_err: got %0b want 0", tag_err); else passed++;
        cycle();
        pe_mode = 0;
        total++; if (wb_valid !== 1'b1 || wb_phase !== 1'b1 || wb_dst !== 6'd7)
            $display("FAIL wrongph_entry: got v=%0b ph=%0b dst=%0d want v=1 ph=1 dst=7", wb_valid, wb_phase, wb_dst);
        else passed++;
        total++; if (tag_err !== 1'b1) $display("FAIL wrongph_err: got %0b want 1", tag_err); else passed++;
        wb_ready = 1'b1;
        cycle(); cycle(); cycle();
        total++; if (tag_err !== 1'b1 || wb_valid !== 1'b0)
            $display("FAIL wrongph_sticky: got err=%0b v=%0b want err=1 v=0", tag_err, wb_valid);
        else passed++;
    endtask

    task automatic test_orphan();
        do_reset();
        pe_mode  = 2;
        man_pe   = 2'b10;
        man_dout = 32'hDEAD_BEEF;
        cycle();
        pe_mode = 0;
        total++; if (fifo_level !== 3'd0 || wb_valid !== 1'b0)
            $display("FAIL orphan_push: got lvl=%0d v=%0b want lvl=0 v=0", fifo_level, wb_valid);
        else passed++;
        total++; if (tag_err !== 1'b1) $display("FAIL orphan_err: got %0b want 1", tag_err); else passed++;
    endtask

    task automatic test_both_phase();
        do_reset();
        pe_mode = 3;
        issue(1'b0, 6'd3); cycle();
        idle(); cycle(); cycle();
        pe_mode = 0;
        total++; if (wb_valid !== 1'b1 || wb_phase !== 1'b0 || wb_dst !== 6'd3 || wb_data !== 32'hC0DE_0003)
            $display("FAIL both_entry: got v=%0b ph=%0b dst=%0d d=%h want v=1 ph=0 dst=3 d=c0de0003",
                     wb_valid, wb_phase, wb_dst, wb_data);
        else passed++;
        total++; if (tag_err !== 1'b1) $display("FAIL both_err: got %0b want 1", tag_err); else passed++;
    endtask

    task automatic test_stall_violation();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue(1'b0, DST_W'(i));
            cycle();
        end
        issue(1'b0, 6'd9);
        cycle();
        idle();
        total++; if (tag_err !== 1'b1) $display("FAIL stallviol_err: got %0b want 1", tag_err); else passed++;
        cycle();
        total++; if (fifo_level !== 3'd4) $display("FAIL stallviol_level: got %0d want 4", fifo_level); else passed++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            issue(1'b0, DST_W'(i));
            cycle();
        end
        idle();
        total++; if (fifo_level !== 3'd2) $display("FAIL midrst_pre_level: got %0d want 2", fifo_level); else passed++;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total++; if (wb_valid !== 1'b0 || fifo_level !== 3'd0 || issue_stall !== 1'b0 || tag_err !== 1'b0)
            $display("FAIL midrst_state: got v=%0b lvl=%0d st=%0b err=%0b want all 0",
                     wb_valid, fifo_level, issue_stall, tag_err);
        else passed++;
        cycle();
        total++; if (tag_err !== 1'b1) $display("FAIL midrst_late_err: got %0b want 1", tag_err); else passed++;
        total++; if (fifo_level !== 3'd0 || wb_valid !== 1'b0)
            $display("FAIL midrst_late_push: got lvl=%0d v=%0b want 0 0", fifo_level, wb_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [DST_W-1:0] q[$];
        logic [DST_W-1:0] nd;
        int ops;
        int pops;
        do_reset();
        issue(1'b0, 6'd10); q.push_back(6'd10); cycle();
        issue(1'b0, 6'd11); q.push_back(6'd11); cycle();
        total++; if (issue_stall !== 1'b0) $display("FAIL b2b_stall_c: got %0b want 0", issue_stall); else passed++;
        issue(1'b0, 6'd12); q.push_back(6'd12); cycle();
        idle(); cycle();
        total++; if (fifo_level !== 3'd2) $display("FAIL b2b_level_pre: got %0d want 2", fifo_level); else passed++;
        wb_ready = 1'b1;
        total++; if (wb_dst !== 6'd10) $display("FAIL b2b_head: got %0d want 10", wb_dst); else passed++;
        void'(q.pop_front());
        pops = 1;
        cycle();
        total++; if (fifo_level !== 3'd2) $display("FAIL b2b_level_pushpop: got %0d want 2", fifo_level); else passed++;
        nd  = 6'd13;
        ops = 0;
        for (int c = 0; c < 60 && (ops < 12 || q.size() != 0); c++) begin
            if (wb_valid && wb_ready) begin
                total++;
                if (q.size() == 0 || wb_dst !== q[0] || wb_data !== (32'hC0DE_0000 | 32'(q[0])))
                    $display("FAIL b2b_order: got dst=%0d data=%h want dst=%0d", wb_dst, wb_data,
                             (q.size() != 0) ? q[0] : '0);
                else passed++;
                if (q.size() != 0) void'(q.pop_front());
                pops++;
            end
            if (ops < 12 && !issue_stall) begin
                issue(1'b0, nd);
                q.push_back(nd);
                nd = nd + DST_W'(1);
                ops++;
            end else begin
                idle();
            end
            cycle();
        end
        idle();
        total++; if (pops != 15 || q.size() != 0)
            $display("FAIL b2b_count: got pops=%0d left=%0d want 15 0", pops, q.size());
        else passed++;
        total++; if (wb_valid !== 1'b0 || fifo_level !== 3'd0 || tag_err !== 1'b0)
            $display("FAIL b2b_final: got v=%0b lvl=%0d err=%0b want 0 0 0", wb_valid, fifo_level, tag_err);
        else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        wb_ready = 1'b0;
        phase_en = 2'b00;
        dout     = '0;
        pe_mode  = 0;
        man_pe   = 2'b00;
        man_dout = '0;
        idle();
        for (int i = 0; i < 2; i++) begin
            alu_v[i]  = 1'b0;
            alu_ph[i] = 1'b0;
            alu_d[i]  = '0;
        end
        test_reset();
        test_single();
        test_credit();
        test_wrong_phase();
        test_orphan();
        test_both_phase();
        test_stall_violation();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
